// File: rtl/pep_seq_counter_accum.sv
// Sequencer event counters: one wrap-around counter per increment bit,
// read out one cycle after request with optional clear-on-read.
module pep_seq_counter_accum #(
    parameter  int BATCH_PBS_NB      = 8,
    parameter  int CNT_W             = 32,
    localparam int CNT_NB            = 7 + BATCH_PBS_NB,
    localparam int IDX_W             = $clog2(CNT_NB),
    localparam int SEQ_COUNTER_INC_W = CNT_NB
) (
    input  logic                         clk,
    input  logic                         s_rst_n,
    input  logic [SEQ_COUNTER_INC_W-1:0] seq_counter_inc,
    input  logic                         rd_req,
    input  logic [IDX_W-1:0]             rd_idx,
    input  logic                         rd_clr,
    input  logic                         clr_all,
    output logic                         rd_vld,
    output logic [CNT_W-1:0]             rd_data,
    output logic                         rd_err
);

    // Bit i of seq_counter_inc drives counter i:
    // 0 ipip_flush, 1 bpip_waiting_batch, 2.. batch_filling[],
    // then batch_flush, batch_timeout, batch, load_ack, cmux_not_full_batch.
    logic [SEQ_COUNTER_INC_W-1:0] inc_q;
    logic [CNT_W-1:0]             cnt_q [CNT_NB];
    logic [CNT_W-1:0]             cnt_d [CNT_NB];
    logic [CNT_NB-1:0]            clr_vec;

    logic                         idx_ok;
    logic                         rd_vld_q;
    logic                         rd_vld_d;
    logic [CNT_W-1:0]             rd_data_q;
    logic [CNT_W-1:0]             rd_data_d;
    logic                         rd_err_q;
    logic                         rd_err_d;

    assign idx_ok = ({1'b0, rd_idx} < (IDX_W+1)'(CNT_NB));

    // Clear is applied first, so a same-edge increment lands on zero.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < CNT_NB; i++) begin
            clr_vec[i] = clr_all
                       | (rd_req & rd_clr & (rd_idx == IDX_W'(i)));
            cnt_d[i]   = (clr_vec[i] ? '0 : cnt_q[i])
                       + CNT_W'(inc_q[i]);
        end
    end

    always_comb begin
        rd_vld_d  = rd_req;
        rd_err_d  = rd_req & ~idx_ok;
        rd_data_d = '0;
        if (rd_req && idx_ok) begin
            rd_data_d = cnt_q[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            inc_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
            for (int i = 0; i < CNT_NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            inc_q     <= seq_counter_inc;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
            for (int i = 0; i < CNT_NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rd_vld  = rd_vld_q;
    assign rd_data = rd_data_q;
    assign rd_err  = rd_err_q;

endmodule

// File: tb/tb_pep_seq_counter_accum.sv
// Randomised and directed checks of pep_seq_counter_accum against
// an event-count reference model; a narrow instance exercises wrap-around.
module tb_pep_seq_counter_accum;

    localparam int B   = 8;
    localparam int W   = 32;
    localparam int NB  = 7 + B;
    localparam int IW  = $clog2(NB);
    localparam int B2  = 2;
    localparam int W2  = 4;
    localparam int NB2 = 7 + B2;
    localparam int IW2 = $clog2(NB2);
    localparam longint unsigned MASK = (64'd1 << W) - 1;

    logic          clk = 1'b0;
    logic          s_rst_n;
    logic [NB-1:0] inc;
    logic          rd_req;
    logic [IW-1:0] rd_idx;
    logic          rd_clr;
    logic          clr_all;
    logic          rd_vld;
    logic [W-1:0]  rd_data;
    logic          rd_err;

    logic [NB2-1:0] inc2;
    logic           rd_req2;
    logic [IW2-1:0] rd_idx2;
    logic           rd_clr2;
    logic           clr_all2;
    logic           rd_vld2;
    logic [W2-1:0]  rd_data2;
    logic           rd_err2;

    pep_seq_counter_accum #(.BATCH_PBS_NB(B), .CNT_W(W)) dut (
        .clk(clk), .s_rst_n(s_rst_n), .seq_counter_inc(inc),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_clr(rd_clr),
        .clr_all(clr_all), .rd_vld(rd_vld), .rd_data(rd_data),
        .rd_err(rd_err)
    );

    pep_seq_counter_accum #(.BATCH_PBS_NB(B2), .CNT_W(W2)) dut_w (
        .clk(clk), .s_rst_n(s_rst_n), .seq_counter_inc(inc2),
        .rd_req(rd_req2), .rd_idx(rd_idx2), .rd_clr(rd_clr2),
        .clr_all(clr_all2), .rd_vld(rd_vld2), .rd_data(rd_data2),
        .rd_err(rd_err2)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: event counts per counter, plus the increments
    // captured at the previous edge which land at the next edge.
    longint unsigned m_cnt [NB];
    bit              m_pend[NB];
    bit              e_vld;
    bit              e_err;
    longint unsigned e_data;

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_cnt[i]  = 0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic tick(input string tag);
        int idx;
        idx    = int'(rd_idx);
        e_vld  = rd_req;
        e_err  = rd_req && (idx >= NB);
        e_data = (rd_req && idx < NB) ? m_cnt[idx] : 0;
        for (int i = 0; i < NB; i++) begin
            if (clr_all || (rd_req && rd_clr && idx == i))
                m_cnt[i] = 0;
            m_cnt[i]  = (m_cnt[i] + longint'(m_pend[i])) & MASK;
            m_pend[i] = inc[i];
        end
        @(posedge clk);
        #1;
        chk({tag, ".vld"}, 64'(rd_vld), 64'(e_vld));
        chk({tag, ".data"}, 64'(rd_data), e_data);
        chk({tag, ".err"}, 64'(rd_err), 64'(e_err));
    endtask

    task automatic rd(input int idx, input logic clr, input string tag);
        rd_req = 1'b1;
        rd_idx = IW'(idx);
        rd_clr = clr;
        tick(tag);
        rd_req = 1'b0;
        rd_clr = 1'b0;
    endtask

    task automatic rd2(input int idx, input string tag,
                       input logic [63:0] exp);
        rd_req2 = 1'b1;
        rd_idx2 = IW2'(idx);
        tick({tag, ".bg"});
        rd_req2 = 1'b0;
        chk({tag, ".vld"}, 64'(rd_vld2), 64'd1);
        chk({tag, ".data"}, 64'(rd_data2), exp);
        chk({tag, ".err"}, 64'(rd_err2), 64'd0);
    endtask

    task automatic do_reset(input logic [NB-1:0] inc_at_release);
        @(negedge clk);
        s_rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.async_vld", 64'(rd_vld), 64'd0);
        @(posedge clk);
        #1;
        chk("rst.vld", 64'(rd_vld), 64'd0);
        chk("rst.data", 64'(rd_data), 64'd0);
        chk("rst.err", 64'(rd_err), 64'd0);
        rd_req = 1'b0;
        inc    = inc_at_release;
        @(negedge clk);
        s_rst_n = 1'b1;
    endtask

    initial begin
        s_rst_n  = 1'b0;
        inc      = '0;
        rd_req   = 1'b0;
        rd_idx   = '0;
        rd_clr   = 1'b0;
        clr_all  = 1'b0;
        inc2     = '0;
        rd_req2  = 1'b0;
        rd_idx2  = '0;
        rd_clr2  = 1'b0;
        clr_all2 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init.vld", 64'(rd_vld), 64'd0);
        chk("init.data", 64'(rd_data), 64'd0);
        chk("init.err", 64'(rd_err), 64'd0);
        @(negedge clk);
        s_rst_n = 1'b1;

        for (int i = 0; i < NB; i++) rd(i, 1'b0, "post_rst");

        // load_ack pulsed five times
        inc[5+B] = 1'b1;
        repeat (5) tick("ldack_inc");
        inc = '0;
        tick("ldack_drain");
        rd(5 + B, 1'b0, "ldack_rd");
        chk("ldack.val", 64'(rd_data), 64'd5);
        chk("ldack.err", 64'(rd_err), 64'd0);

        // every bit for three cycles
        clr_all = 1'b1;
        tick("clr_all");
        clr_all = 1'b0;
        inc = '1;
        repeat (3) tick("all_inc");
        inc = '0;
        tick("all_drain");
        for (int i = 0; i < NB; i++) begin
            rd(i, 1'b0, "all_rd");
            chk("all3.val", 64'(rd_data), 64'd3);
        end

        // clear-on-read racing a registered increment
        inc[1] = 1'b1;
        tick("race_inc");
        inc = '0;
        rd(1, 1'b1, "race_clr");
        chk("race.old", 64'(rd_data), 64'd3);
        rd(1, 1'b0, "race_after");
        chk("race.one", 64'(rd_data), 64'd1);

        // out-of-range index
        rd(NB, 1'b0, "oob");
        chk("oob.data", 64'(rd_data), 64'd0);
        chk("oob.err", 64'(rd_err), 64'd1);
        rd(NB, 1'b1, "oob_clr");
        for (int i = 0; i < NB; i++) rd(i, 1'b0, "oob_after");
        rd(0, 1'b0, "oob_c0");
        chk("oob.c0", 64'(rd_data), 64'd3);

        // wrap on the narrow instance: preset to max-1 then two pulses
        inc2[0] = 1'b1;
        repeat (14) tick("wrap_pre");
        inc2 = '0;
        tick("wrap_pre_drain");
        rd2(0, "wrap_preset", 64'd14);
        inc2[0] = 1'b1;
        repeat (2) tick("wrap_inc");
        inc2 = '0;
        tick("wrap_drain");
        rd2(0, "wrap", 64'd0);

        // randomised traffic
        for (int n = 0; n < 400; n++) begin
            inc     = NB'($urandom);
            rd_req  = 1'($urandom_range(0, 1));
            rd_idx  = IW'($urandom_range(0, NB));
            rd_clr  = ($urandom_range(0, 3) == 0);
            clr_all = ($urandom_range(0, 40) == 0);
            tick("rand");
        end
        inc = '0; rd_req = 1'b0; rd_clr = 1'b0; clr_all = 1'b0;
        tick("rand_drain");
        for (int i = 0; i <= NB; i++) rd(i, 1'b0, "rand_sweep");

        // counters at 7, read pending when reset hits
        clr_all = 1'b1;
        tick("r7_clr");
        clr_all = 1'b0;
        inc = '1;
        repeat (7) tick("r7_inc");
        inc = '0;
        tick("r7_drain");
        rd(4, 1'b0, "r7_rd");
        chk("r7.val", 64'(rd_data), 64'd7);
        rd_req = 1'b1;
        rd_idx = IW'(3);
        do_reset('0);
        tick("r7_after");
        chk("r7.no_vld", 64'(rd_vld), 64'd0);
        for (int i = 0; i < NB; i++) begin
            rd(i, 1'b0, "r7_zero");
            chk("r7.zero", 64'(rd_data), 64'd0);
        end

        // pulse present at the first edge after release is counted
        do_reset(NB'(1));
        tick("rel_inc");
        inc = '0;
        tick("rel_drain");
        rd(0, 1'b0, "rel_rd");
        chk("rel.val", 64'(rd_data), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
